id_ex_stage_reg: RTL

//  Decode->execute pipeline register for the 5-stage core; sits directly downstream of the 32x32 register file.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage_reg.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Constants and helpers shared by the decode/execute pipeline
//               register and its hazard detector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Default width of the opaque EX/MEM/WB control bundle
  localparam int CTRL_W_DEF = 8;

  // Architectural zero register: never written, never a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bundle bit positions (the stage passes the bundle through unchanged)
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_BRANCH     = 7;

  // Control bundle of an instruction with no side effects
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // True when a producer index is a real register and matches the consumer index
  function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Load-use hazard equation between the instruction in EX and
//               the instruction in decode. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard
);

  logic w_rs_dep;
  logic w_rt_dep;

  // A zero destination never matches, so register 0 sources cannot stall
  assign w_rs_dep = reg_match(ex_dest, id_rs);
  assign w_rt_dep = reg_match(ex_dest, id_rt);
  assign hazard   = ex_valid & ex_mem_read & id_valid & (w_rs_dep | w_rt_dep);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : Decode->execute pipeline register. Captures operands,
//               immediate, destination and control bundle; inserts one bubble
//               on a load-use hazard and counts bubbles (saturating).
//               Optional macro WB_BYPASS_EN forwards a same-edge write-back
//               into the captured source operands.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd_dest,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  output logic              stall_ifid,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_rs_data;
  logic [31:0]       r_rt_data;
  logic [31:0]       r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_dest;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_mem_read;
  logic              r_reg_write;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_hazard;
  logic [31:0]       w_rs_data;
  logic [31:0]       w_rt_data;

  load_use_detect u_load_use_detect (
    .ex_valid    (r_valid),
    .ex_mem_read (r_mem_read),
    .ex_dest     (r_dest),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (w_hazard)
  );

  // Flush kills the decode slot, so it also cancels any stall request
  assign stall_ifid = (w_hazard | ex_hold) & ~flush;

`ifdef WB_BYPASS_EN
  // A write-back landing on the same edge supersedes the stale register-file read
  assign w_rs_data = (wb_en && reg_match(wb_reg, id_rs)) ? wb_data : id_rs_data;
  assign w_rt_data = (wb_en && reg_match(wb_reg, id_rt)) ? wb_data : id_rt_data;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_reg, wb_data};
  assign w_rs_data   = id_rs_data;
  assign w_rt_data   = id_rt_data;
`endif

  // Stage register: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_ctrl       <= '0;
      r_mem_read   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_ctrl       <= CTRL_W'(CTRL_NOP);
      r_mem_read   <= 1'b0;
      r_reg_write  <= 1'b0;
    end else if (ex_hold) begin
      r_valid      <= r_valid;
    end else if (w_hazard) begin
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_reg_write  <= 1'b0;
      if (r_bubble_cnt != C_CNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_valid      <= id_valid;
      r_pc         <= id_pc;
      r_rs_data    <= w_rs_data;
      r_rt_data    <= w_rt_data;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_dest       <= id_rd_dest;
      r_ctrl       <= id_ctrl;
      r_mem_read   <= id_mem_read & id_valid;
      r_reg_write  <= id_reg_write & id_valid;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_dest      = r_dest;
  assign ex_ctrl      = r_ctrl;
  assign ex_mem_read  = r_mem_read;
  assign ex_reg_write = r_reg_write;
  assign bubble_cnt   = r_bubble_cnt;

endmodule
`default_nettype wire
